add_1bit: RTL and testbench
===========================

# add_1bit

One-bit binary adder with a combinational sum/carry path and a registered, valid-qualified copy of the result. The block is the basic arithmetic leaf cell used by wider adders and counters. With `CI` tied low it is a half adder: `O = A ^ B`, `C = A & B`. It also keeps a saturating count of carry-out events for debug and coverage.

## Interface
Parameters:
- `CNT_WIDTH`, default 8: width of `carry_count`, minimum 1.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `A`  input  1  addend bit.
- `B`  input  1  addend bit.
- `CI`  input  1  carry-in; tie to 0 for half-adder use.
- `in_valid`  input  1  qualifies `A`/`B`/`CI` for the registered path and the carry counter.
- `count_clr`  input  1  synchronous clear of `carry_count`.
- `O`  output  1  combinational sum.
- `C`  output  1  combinational carry-out.
- `O_r`  output  1  registered sum.
- `C_r`  output  1  registered carry-out.
- `out_valid`  output  1  `in_valid` delayed by one cycle.
- `carry_count`  output  CNT_WIDTH  saturating count of valid carry-outs.

## Operation
- Combinational path:
  - `O = A ^ B ^ CI`.
  - `C = (A & B) | (CI & (A ^ B))`.
  - Purely combinational; independent of `clk` and `reset`. It stays valid even while `reset` is asserted.
- Registered path: on a rising edge of `clk` with `in_valid = 1`, load `O_r <= O` and `C_r <= C`.
  - With `in_valid = 0`, `O_r` and `C_r` hold their value.
  - `out_valid <= in_valid` on every edge.
- Carry counter, evaluated on every rising edge, in priority order:
  1. `count_clr = 1`: `carry_count <= 0`, regardless of the other inputs.
  2. `in_valid & C` with `carry_count` below all-ones: increment by 1.
  3. `in_valid & C` with `carry_count` at all-ones: hold (saturate, no wrap).
  4. Otherwise: hold.
- Reset (`reset = 0`): `O_r`, `C_r`, `out_valid` and `carry_count` go to 0 immediately, without waiting for a clock edge. They stay 0 while reset is held.
- Reset release: state updates resume on the first rising edge after `reset` returns high. No extra flush cycle.
- X/unknown inputs on `A`/`B`/`CI` propagate to `O`/`C`. No masking.

## Timing
- `O`, `C`: zero-cycle latency, combinational from `A`/`B`/`CI`.
- `O_r`, `C_r`, `out_valid`: one-cycle latency. A value sampled at edge N is visible after edge N.
- `carry_count`: reflects carries sampled up to and including the previous edge.
- Reset asserted mid-operation clears all registers at once. A sample that was in flight is dropped and `out_valid` reads 0.
- No handshake backpressure. Every valid sample is accepted on every cycle.

## Test plan
- Exhaustive truth table with `CI = 0`, driving {B,A} = 00, 01, 10, 11 (a 2-bit counter). Required `O`/`C`: 0/0, 1/0, 1/0, 0/1.
- Full-adder check with `CI = 1`:
  - A=1, B=1 gives `O=1`, `C=1`.
  - A=0, B=0 gives `O=1`, `C=0`.
  - A=1, B=0 gives `O=0`, `C=1`.
- Registered latency: A=1, B=1, CI=0, `in_valid=1` for one cycle, then `in_valid=0` with A=0. Required: `C_r=1`, `O_r=0`, `out_valid=1` one cycle after the valid sample; values hold and `out_valid=0` on the next cycle.
- Reset: hold `reset=0` from time 10 for 300 time units while stimulus toggles. Required:
  - Registered outputs and `carry_count` stay 0 throughout.
  - `O`/`C` track the inputs throughout.
  - Asserting reset mid-run clears `O_r`/`C_r` immediately, without waiting for a clock edge.
- Saturation with `CNT_WIDTH=2`: 5 consecutive valid samples with A=B=1. Required: `carry_count` goes 1, 2, 3, 3, 3.
- Clear priority: `count_clr=1` in the same cycle as a valid carry. Required: `carry_count=0` after the edge; next valid carry gives 1.

Source files
------------

// File: rtl/add_1bit.sv
// One-bit full adder with a combinational sum/carry, a valid-qualified
// registered copy of the result, and a saturating carry-out event counter.
module add_1bit #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 A,
    input  logic                 B,
    input  logic                 CI,
    input  logic                 in_valid,
    input  logic                 count_clr,
    output logic                 O,
    output logic                 C,
    output logic                 O_r,
    output logic                 C_r,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] carry_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 half_sum;
    logic                 count_inc;
    logic [CNT_WIDTH-1:0] carry_count_nxt;

    // Combinational sum/carry; deliberately independent of clk/reset
    assign half_sum = A ^ B;
    assign O        = half_sum ^ CI;
    assign C        = (A & B) | (CI & half_sum);

    // Clear wins over increment; increment stops at all-ones
    assign count_inc = in_valid & C & (carry_count != CNT_MAX);

    always_comb begin
        carry_count_nxt = carry_count;
        if (count_clr) begin
            carry_count_nxt = '0;
        end else if (count_inc) begin
            carry_count_nxt = carry_count + CNT_WIDTH'(1);
        end
    end

    // Registered result holds while in_valid is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            O_r       <= 1'b0;
            C_r       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                O_r <= O;
                C_r <= C;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_count <= '0;
        end else begin
            carry_count <= carry_count_nxt;
        end
    end

endmodule

// File: tb/tb_add_1bit.sv
// Directed bench for add_1bit: expected registered results are queued when a
// sample is driven and compared one edge later.
module tb_add_1bit;

    localparam int unsigned CW = 2;

    typedef struct packed {
        logic          o_r;
        logic          c_r;
        logic          ov;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          A, B, CI;
    logic          in_valid;
    logic          count_clr;
    logic          O, C, O_r, C_r, out_valid;
    logic [CW-1:0] carry_count;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];

    logic          m_or, m_cr, m_ov;
    logic [CW-1:0] m_cnt;

    add_1bit #(.CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .CI         (CI),
        .in_valid   (in_valid),
        .count_clr  (count_clr),
        .O          (O),
        .C          (C),
        .O_r        (O_r),
        .C_r        (C_r),
        .out_valid  (out_valid),
        .carry_count(carry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_O_r"}, 8'(O_r), 8'd0);
        check({tag, "_C_r"}, 8'(C_r), 8'd0);
        check({tag, "_ov"}, 8'(out_valid), 8'd0);
        check({tag, "_cnt"}, 8'(carry_count), 8'd0);
    endtask

    // Drive one sample, check the combinational outputs, then check the
    // registered outputs one edge later against the queued expectation.
    task automatic step(input string tag, input logic a, input logic b, input logic ci,
                        input logic v, input logic clr);
        exp_t e;
        logic es, ec;
        A = a; B = b; CI = ci; in_valid = v; count_clr = clr;
        es = a ^ b ^ ci;
        ec = (a & b) | (a & ci) | (b & ci);
        #1;
        check({tag, "_O"}, 8'(O), 8'(es));
        check({tag, "_C"}, 8'(C), 8'(ec));
        if (!reset) begin
            m_or = 1'b0; m_cr = 1'b0; m_ov = 1'b0; m_cnt = '0;
        end else begin
            m_ov = v;
            if (v) begin
                m_or = es;
                m_cr = ec;
            end
            if (clr) m_cnt = '0;
            else if (v && ec && (int'(m_cnt) < (1 << CW) - 1)) m_cnt = m_cnt + CW'(1);
        end
        q.push_back('{o_r: m_or, c_r: m_cr, ov: m_ov, cnt: m_cnt});
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({tag, "_O_r"}, 8'(O_r), 8'(e.o_r));
        check({tag, "_C_r"}, 8'(C_r), 8'(e.c_r));
        check({tag, "_ov"}, 8'(out_valid), 8'(e.ov));
        check({tag, "_cnt"}, 8'(carry_count), 8'(e.cnt));
    endtask

    initial begin
        reset = 1'b0; A = 1'b0; B = 1'b0; CI = 1'b0; in_valid = 1'b0; count_clr = 1'b0;
        m_or = 1'b0; m_cr = 1'b0; m_ov = 1'b0; m_cnt = '0;
        #1;
        check_regs_zero("reset_state");

        // Load a nonzero registered result before the mid-run reset
        #1 reset = 1'b1;
        step("preload", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Mid-cycle reset must clear registers without a clock edge
        #4 reset = 1'b0;
        m_or = 1'b0; m_cr = 1'b0; m_ov = 1'b0; m_cnt = '0;
        #1;
        check_regs_zero("async_clear");

        // Reset held until t=310 while stimulus toggles
        for (int i = 0; i < 30; i++) begin
            step("in_reset", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        #4 reset = 1'b1;

        // Half-adder truth table, {B,A} counting 00..11
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ba;
            ba = 2'(i);
            step("half", ba[0], ba[1], 1'b0, 1'b1, 1'b0);
        end

        // Full-adder cases with CI=1
        step("full_11", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step("full_00", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("full_10", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Registered latency and hold when in_valid drops
        step("lat_load", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step("lat_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation at all-ones
        step("sat_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step("sat", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end

        // Clear beats a simultaneous valid carry
        step("clr_prio", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step("clr_next", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            step("rand", 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
